// File: rtl/div_unit_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  function automatic logic op_is_signed(div_op_t op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic op_is_rem(div_op_t op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Launch and result handshakes between the execute stage (master) and the divider (slave).
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  import div_unit_pkg::*;

  logic             start_valid;
  logic             start_ready;
  div_op_t          op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             result_zero;

  modport master (
    output start_valid, op, dividend, divisor, result_ready,
    input  start_ready, result_valid, result, result_zero
  );

  modport slave (
    input  start_valid, op, dividend, divisor, result_ready,
    output start_ready, result_valid, result, result_zero
  );

endinterface

// File: rtl/div_sign_conv.sv
// Conditional two's-complement negate, used for operand magnitudes and result fix-up.
module div_sign_conv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_negate,
  output logic [WIDTH-1:0] o_value
);

  assign o_value = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/div_unit.sv
// Restoring shift-and-subtract divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional DIV_EARLY_OUT_EN: |dividend| < |divisor| completes one edge after acceptance.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  div_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  div_state_t       r_state;
  div_op_t          r_op;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_result;
  logic [CntW-1:0]  r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;

  logic             w_signed, w_neg_a, w_neg_b, w_accept;
  logic             w_div_zero, w_ovf, w_early, w_fast;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_fast_quo, w_fast_rem, w_fast_res;
  logic [WIDTH-1:0] w_quo_fix, w_rem_fix;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;

  assign w_signed   = op_is_signed(bus.op);
  assign w_neg_a    = w_signed & bus.dividend[WIDTH-1];
  assign w_neg_b    = w_signed & bus.divisor[WIDTH-1];
  assign w_accept   = bus.start_valid && (r_state == DIV_IDLE);
  assign w_div_zero = (bus.divisor == '0);
  assign w_ovf      = w_signed && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (bus.divisor == '1);

  div_sign_conv #(.WIDTH(WIDTH)) u_abs_a (
    .i_value (bus.dividend),
    .i_negate(w_neg_a),
    .o_value (w_a_mag)
  );

  div_sign_conv #(.WIDTH(WIDTH)) u_abs_b (
    .i_value (bus.divisor),
    .i_negate(w_neg_b),
    .o_value (w_b_mag)
  );

`ifdef DIV_EARLY_OUT_EN
  assign w_early = !w_div_zero && (w_a_mag < w_b_mag);
`else
  assign w_early = 1'b0;
`endif

  assign w_fast = w_div_zero | w_ovf | w_early;

  // Divide-by-zero is the default; the other fast cases never coincide with it.
  always_comb begin
    w_fast_quo = '1;
    w_fast_rem = bus.dividend;
    if (w_ovf) begin
      w_fast_quo = bus.dividend;
      w_fast_rem = '0;
    end else if (w_early) begin
      w_fast_quo = '0;
      w_fast_rem = bus.dividend;
    end
  end

  assign w_fast_res = op_is_rem(bus.op) ? w_fast_rem : w_fast_quo;

  // Partial remainder is kept below the divisor, so one extra bit covers the shifted value.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});

  div_sign_conv #(.WIDTH(WIDTH)) u_fix_quo (
    .i_value (r_quo),
    .i_negate(r_sign_q),
    .o_value (w_quo_fix)
  );

  div_sign_conv #(.WIDTH(WIDTH)) u_fix_rem (
    .i_value (r_rem),
    .i_negate(r_sign_r),
    .o_value (w_rem_fix)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= DIV_IDLE;
      r_op     <= DIV_DIV;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_op     <= bus.op;
            r_sign_q <= w_neg_a ^ w_neg_b;
            r_sign_r <= w_neg_a;
            r_cnt    <= '0;
            if (w_fast) begin
              r_result <= w_fast_res;
              r_state  <= DIV_DONE;
            end else begin
              r_quo   <= w_a_mag;
              r_rem   <= '0;
              r_div   <= w_b_mag;
              r_state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_rem <= w_ge ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == CntLast) r_state <= DIV_FIX;
        end
        DIV_FIX: begin
          r_result <= op_is_rem(r_op) ? w_rem_fix : w_quo_fix;
          r_state  <= DIV_DONE;
        end
        DIV_DONE: begin
          if (bus.result_ready) r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign bus.start_ready  = (r_state == DIV_IDLE);
  assign bus.result_valid = (r_state == DIV_DONE);
  assign bus.result       = r_result;
  assign bus.result_zero  = (r_state == DIV_DONE) && (r_result == '0);

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against a scoreboard of expected result/latency.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total  = 0;
  int passed = 0;

  logic [31:0] q_res[$];
  bit          q_zero[$];
  int          q_lat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] res, input int lat);
    q_res.push_back(res);
    q_zero.push_back(res == 32'd0);
    q_lat.push_back(lat);
  endtask

  // Called at accepting edge + 1; latency counts that edge as 1.
  task automatic collect(input string tag);
    int          lat;
    logic [31:0] er;
    bit          ez;
    int          el;
    lat = 1;
    while (bus.result_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    er = q_res.pop_front();
    ez = q_zero.pop_front();
    el = q_lat.pop_front();
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " result"}, bus.result, er);
    chk({tag, " zero"}, {31'b0, bus.result_zero}, {31'b0, ez});
  endtask

  task automatic run_op(input string tag, input div_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    push(exp, lat);
    @(negedge clk);
    chk({tag, " start_ready"}, {31'b0, bus.start_ready}, 32'd1);
    bus.start_valid = 1'b1;
    bus.op          = op;
    bus.dividend    = a;
    bus.divisor     = b;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    collect(tag);
    if (bus.result_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] mag(input bit sgn, input logic [31:0] x);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          seen;
    bit          sgn, is_rem;
    logic [31:0] a, b, exp;
    int          sa, sb, lat;
    div_op_t     op;

    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b1;
    bus.op           = DIV_DIV;
    bus.dividend     = '0;
    bus.divisor      = '0;
    reset            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset start_ready", {31'b0, bus.start_ready}, 32'd1);
    chk("reset result_valid", {31'b0, bus.result_valid}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset result_zero", {31'b0, bus.result_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("div 100/7", DIV_DIV, 32'd100, 32'd7, 32'd14, 34);
    run_op("rem 100/7", DIV_REM, 32'd100, 32'd7, 32'd2, 34);
    run_op("div -7/2", DIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem -7/2", DIV_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu big/2", DIV_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);

    run_op("divu /0", DIV_DIVU, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu /0", DIV_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    run_op("rem -7/0", DIV_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
    run_op("div ovf", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    run_op("div 3/10", DIV_DIV, 32'd3, 32'd10, 32'd0, Early ? 1 : 34);
    run_op("rem 3/10", DIV_REM, 32'd3, 32'd10, 32'd3, Early ? 1 : 34);
    run_op("rem -3/10", DIV_REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, Early ? 1 : 34);

    // Result held while the consumer stalls; a request during DONE must be ignored.
    bus.result_ready = 1'b0;
    run_op("remu 6/3", DIV_REMU, 32'd6, 32'd3, 32'd0, 34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start_valid = 1'b1;
      bus.op          = DIV_DIVU;
      bus.dividend    = 32'd50;
      bus.divisor     = 32'd5;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d result", i), bus.result, 32'd0);
      chk($sformatf("hold%0d zero", i), {31'b0, bus.result_zero}, 32'd1);
      chk($sformatf("hold%0d valid", i), {31'b0, bus.result_valid}, 32'd1);
      chk($sformatf("hold%0d start_ready", i), {31'b0, bus.start_ready}, 32'd0);
    end
    push(32'd10, 34);
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release start_ready", {31'b0, bus.start_ready}, 32'd1);
    chk("release result_valid", {31'b0, bus.result_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    collect("divu after hold");
    @(posedge clk);
    #1;

    // Reset sampled on the 10th CALC iteration edge abandons the op.
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.op          = DIV_DIVU;
    bus.dividend    = 32'd1000;
    bus.divisor     = 32'd3;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midcalc reset start_ready", {31'b0, bus.start_ready}, 32'd1);
    chk("midcalc reset result_valid", {31'b0, bus.result_valid}, 32'd0);
    chk("midcalc reset result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.result_valid === 1'b1) seen++;
    end
    chk("abandoned op silent", 32'(seen), 32'd0);
    run_op("divu 50/5", DIV_DIVU, 32'd50, 32'd5, 32'd10, 34);

    for (int i = 0; i < 8; i++) begin
      sgn    = 1'($urandom_range(0, 1));
      is_rem = 1'($urandom_range(0, 1));
      a      = $urandom;
      b      = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd1;
      if (sgn && b == 32'hFFFF_FFFF) b = 32'd3;
      sa = a;
      sb = b;
      if (sgn) exp = is_rem ? 32'(sa % sb) : 32'(sa / sb);
      else     exp = is_rem ? (a % b) : (a / b);
      op  = sgn ? (is_rem ? DIV_REM : DIV_DIV) : (is_rem ? DIV_REMU : DIV_DIVU);
      lat = (Early && (mag(sgn, a) < mag(sgn, b))) ? 1 : 34;
      run_op($sformatf("rnd%0d %s 0x%08h/0x%08h", i, op.name(), a, b), op, a, b, exp, lat);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
